sim_halt_ctrl: RTL and testbench
================================

# sim_halt_ctrl

Parametrised run-control block for the CPU testbench top. It watches one or more RVFI commit channels plus the RVFI error code and decides when and why simulation ends: architectural halt, error (after a drain window), global timeout, or a no-progress watchdog. It generalises the fixed single-channel halt/timeout/errcode logic into a synthesizable, multi-channel block with a latched termination cause and run statistics. The testbench calls `$finish` on `done` and prints `status`/`err_latched`.

## Interface
Parameters:
- NUM_CH, 1, number of commit channels (superscalar retire width), 1..8
- CNT_W, 32, width of cycle and idle counters
- TIMEOUT_CYCLES, 100000000, global run limit in cycles; 0 disables
- STALL_CYCLES, 100000, max consecutive cycles with no commit; 0 disables
- DRAIN_CYCLES, 5, cycles between error detection and `done`
- ERR_W, 16, errcode width

Ports:
- clk  in  1  testbench clock
- rst  in  1  reset, synchronous, active-high
- commit  in  NUM_CH  per-channel retire valid
- halt  in  NUM_CH  per-channel halt flag, meaningful only with matching `commit` bit
- errcode  in  ERR_W  monitor error code, nonzero = error
- done  out  1  simulation must end; sticky until rst
- status  out  3  cause: 0 RUNNING, 1 HALT, 2 ERROR, 3 TIMEOUT, 4 STALL
- err_latched  out  ERR_W  first nonzero errcode captured
- cycle_count  out  CNT_W  cycles spent in RUN/DRAIN since reset
- commit_count  out  64  total retired instructions

## Operation
- FSM states: RUN, DRAIN, DONE. Reset → RUN.
- Events sampled in RUN each edge:
  - E_err: errcode != 0.
  - E_halt: any channel i with commit[i] & halt[i].
  - E_to: TIMEOUT_CYCLES != 0 and cycle_count + 1 == TIMEOUT_CYCLES.
  - E_st: STALL_CYCLES != 0, no commit bit set, and idle_count + 1 == STALL_CYCLES.
- Priority on simultaneous events: ERROR > HALT > TIMEOUT > STALL. Exactly one cause recorded.
- RUN→DRAIN on E_err when DRAIN_CYCLES > 0 (status=2, err_latched=errcode, drain counter loaded DRAIN_CYCLES-1); RUN→DONE on E_err when DRAIN_CYCLES = 0.
- RUN→DONE on E_halt/E_to/E_st with corresponding status.
- DRAIN: counter decrements each edge; at 0 → DONE. All inputs ignored in DRAIN (later halt/error do not change status or err_latched).
- DONE: absorbing until rst; counters frozen.
- commit_count += popcount(commit) in RUN and DRAIN; wraps mod 2^64. Halting instruction is counted.
- cycle_count increments in RUN and DRAIN, saturates at all-ones.
- idle_count (internal, CNT_W) clears on any commit bit, else increments in RUN; saturates.

## Timing
- Reset values: done=0, status=0, err_latched=0, cycle_count=0, commit_count=0, idle_count=0, state RUN.
- rst high at an edge overrides everything, including mid-DRAIN and DONE.
- Halt sampled at edge k: done=1, status=1 visible after edge k (one-cycle latency, registered outputs).
- Error sampled at edge k: status=2 and err_latched visible after edge k; done visible after edge k+DRAIN_CYCLES.
- Timeout: done visible after the edge where cycle_count reaches TIMEOUT_CYCLES.
- Stall: done after STALL_CYCLES consecutive commit-free RUN cycles.
- All outputs registered; no combinational input→output path.

## Test plan
- NUM_CH=1: reset 5 cycles, 10 commits, commit+halt on 11th at edge k → done=1, status=1 after edge k, commit_count=11; done stays 1 for 20 more cycles.
- NUM_CH=2: commit=2'b11 for 4 cycles, then commit=2'b10, halt=2'b01 → no halt (halt bit without matching commit); then commit=2'b11, halt=2'b10 → status=1, commit_count=12.
- errcode=7 at edge k, DRAIN_CYCLES=5, halt asserted at k+2 → status=2, err_latched=7, done rises after edge k+5, status unchanged by halt.
- errcode=3 and commit+halt same edge → status=2 (error wins); rst at k+2 mid-DRAIN → all outputs 0, state RUN, done never asserts.
- TIMEOUT_CYCLES=50, STALL_CYCLES=0, commits every cycle → done after cycle_count=50, status=3; STALL_CYCLES=8, no commits → done after 8 cycles, status=4, cycle_count=8.

Source files
------------

// File: rtl/sim_halt_ctrl.sv
// rtl/sim_halt_ctrl.sv - run-control: halt/error/timeout/stall detection with latched cause and run statistics
module sim_halt_ctrl #(
   parameter int unsigned NUM_CH         = 1,
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned TIMEOUT_CYCLES = 100000000,
   parameter int unsigned STALL_CYCLES   = 100000,
   parameter int unsigned DRAIN_CYCLES   = 5,
   parameter int unsigned ERR_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] commit,
   input  logic [NUM_CH-1:0] halt,
   input  logic [ERR_W-1:0]  errcode,
   output logic              done,
   output logic [2:0]        status,
   output logic [ERR_W-1:0]  err_latched,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [63:0]       commit_count
);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [2:0] ST_RUNNING = 3'd0;
   localparam logic [2:0] ST_HALT    = 3'd1;
   localparam logic [2:0] ST_ERROR   = 3'd2;
   localparam logic [2:0] ST_TIMEOUT = 3'd3;
   localparam logic [2:0] ST_STALL   = 3'd4;

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] TO_VAL     = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] STALL_VAL  = CNT_W'(STALL_CYCLES);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

   state_t             state, state_n;
   logic [CNT_W-1:0]   idle_count;
   logic [CNT_W-1:0]   drain_count, drain_n;
   logic               done_n;
   logic [2:0]         status_n;
   logic [ERR_W-1:0]   err_n;
   logic [3:0]         commit_pop;
   logic               any_commit;
   logic               ev_err, ev_halt, ev_to, ev_st;

   always_comb begin
      commit_pop = '0;
      for (int i = 0; i < int'(NUM_CH); i++)
         commit_pop = commit_pop + {3'b000, commit[i]};
   end

   assign any_commit = |commit;
   assign ev_err     = |errcode;
   assign ev_halt    = |(commit & halt);
   assign ev_to      = (TIMEOUT_CYCLES != 0) && ((cycle_count + CNT_ONE) == TO_VAL);
   assign ev_st      = (STALL_CYCLES != 0) && !any_commit && ((idle_count + CNT_ONE) == STALL_VAL);

   // Cause priority is fixed by the if/else order: error, halt, timeout, stall.
   always_comb begin
      state_n  = state;
      done_n   = done;
      status_n = status;
      err_n    = err_latched;
      drain_n  = drain_count;
      case (state)
         S_RUN: begin
            if (ev_err) begin
               status_n = ST_ERROR;
               err_n    = errcode;
               if (DRAIN_CYCLES == 0) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end else begin
                  state_n = S_DRAIN;
                  drain_n = DRAIN_LOAD;
               end
            end else if (ev_halt) begin
               state_n  = S_DONE;
               done_n   = 1'b1;
               status_n = ST_HALT;
            end else if (ev_to) begin
               state_n  = S_DONE;
               done_n   = 1'b1;
               status_n = ST_TIMEOUT;
            end else if (ev_st) begin
               state_n  = S_DONE;
               done_n   = 1'b1;
               status_n = ST_STALL;
            end
         end
         S_DRAIN: begin
            if (drain_count == '0) begin
               state_n = S_DONE;
               done_n  = 1'b1;
            end else begin
               drain_n = drain_count - CNT_ONE;
            end
         end
         S_DONE:  state_n = S_DONE;
         default: state_n = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_RUN;
         done         <= 1'b0;
         status       <= ST_RUNNING;
         err_latched  <= '0;
         cycle_count  <= '0;
         commit_count <= '0;
         idle_count   <= '0;
         drain_count  <= '0;
      end else begin
         state       <= state_n;
         done        <= done_n;
         status      <= status_n;
         err_latched <= err_n;
         drain_count <= drain_n;
         if (state != S_DONE) begin
            if (cycle_count != '1)
               cycle_count <= cycle_count + CNT_ONE;
            commit_count <= commit_count + 64'(commit_pop);
         end
         if (state == S_RUN) begin
            if (any_commit)
               idle_count <= '0;
            else if (idle_count != '1)
               idle_count <= idle_count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_sim_halt_ctrl.sv
// tb/tb_sim_halt_ctrl.sv - directed bench for sim_halt_ctrl with an edge-counting reference model
module tb_sim_halt_ctrl;

   localparam int TO = 50;
   localparam int ST = 8;
   localparam int DR = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  commit = '0;
   logic [1:0]  halt = '0;
   logic [15:0] errcode = '0;
   logic        done;
   logic [2:0]  status;
   logic [15:0] err_latched;
   logic [31:0] cycle_count;
   logic [63:0] commit_count;

   int checks = 0;
   int errors = 0;

   sim_halt_ctrl #(
      .NUM_CH(2), .CNT_W(32), .TIMEOUT_CYCLES(TO), .STALL_CYCLES(ST),
      .DRAIN_CYCLES(DR), .ERR_W(16)
   ) dut (
      .clk(clk), .rst(rst), .commit(commit), .halt(halt), .errcode(errcode),
      .done(done), .status(status), .err_latched(err_latched),
      .cycle_count(cycle_count), .commit_count(commit_count)
   );

   always #5 clk = ~clk;

   // Model: the run ends on a recorded cause; an error ends it DR edges later.
   bit          m_valid = 0;
   bit          m_ended, m_err_seen;
   logic [2:0]  m_status;
   logic [15:0] m_err;
   logic [31:0] m_cycles, m_idle, m_err_cyc;
   logic [63:0] m_commits;

   task automatic model_step();
      if (rst) begin
         m_valid = 1; m_ended = 0; m_err_seen = 0; m_status = 0; m_err = 0;
         m_cycles = 0; m_idle = 0; m_err_cyc = 0; m_commits = 0;
      end else if (!m_ended) begin
         if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
         m_commits = m_commits + 64'($countones(commit));
         if (m_err_seen) begin
            if (m_cycles - m_err_cyc == DR) m_ended = 1;
         end else begin
            m_idle = (commit != 0) ? 0 : m_idle + 1;
            if (errcode != 0) begin
               m_status = 2; m_err = errcode; m_err_seen = 1; m_err_cyc = m_cycles;
               if (DR == 0) m_ended = 1;
            end else if ((commit & halt) != 0) begin
               m_status = 1; m_ended = 1;
            end else if (TO != 0 && m_cycles == TO) begin
               m_status = 3; m_ended = 1;
            end else if (ST != 0 && commit == 0 && m_idle == ST) begin
               m_status = 4; m_ended = 1;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_done", 64'(done), 64'(m_ended));
         chk("m_status", 64'(status), 64'(m_status));
         chk("m_err", 64'(err_latched), 64'(m_err));
         chk("m_cycles", 64'(cycle_count), 64'(m_cycles));
         chk("m_commits", commit_count, m_commits);
      end
   end

   task automatic cyc(input logic r, input logic [1:0] c, input logic [1:0] h, input logic [15:0] e);
      rst = r; commit = c; halt = h; errcode = e;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   initial begin
      // single-channel halt
      repeat (5) cyc(1, 0, 0, 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_status", 64'(status), 0);
      chk("rst_err", 64'(err_latched), 0);
      chk("rst_cycles", 64'(cycle_count), 0);
      chk("rst_commits", commit_count, 0);
      repeat (10) cyc(0, 2'b01, 2'b00, 0);
      chk("t1_pre_done", 64'(done), 0);
      cyc(0, 2'b01, 2'b01, 0);
      chk("t1_done", 64'(done), 1);
      chk("t1_status", 64'(status), 1);
      chk("t1_commits", commit_count, 11);
      chk("t1_cycles", 64'(cycle_count), 11);
      repeat (20) cyc(0, 2'b00, 2'b00, 0);
      chk("t1_sticky", 64'(done), 1);
      chk("t1_frozen", 64'(cycle_count), 11);

      // dual-channel: halt without matching commit is ignored
      cyc(1, 0, 0, 0);
      repeat (4) cyc(0, 2'b11, 2'b00, 0);
      repeat (2) cyc(0, 2'b10, 2'b01, 0);
      chk("t2_nohalt", 64'(done), 0);
      cyc(0, 2'b11, 2'b10, 0);
      chk("t2_done", 64'(done), 1);
      chk("t2_status", 64'(status), 1);
      chk("t2_commits", commit_count, 12);

      // error then drain; halt and a new error during drain are ignored
      cyc(1, 0, 0, 0);
      repeat (3) cyc(0, 2'b01, 2'b00, 0);
      cyc(0, 2'b01, 2'b00, 16'd7);
      chk("t3_status", 64'(status), 2);
      chk("t3_err", 64'(err_latched), 7);
      chk("t3_not_done", 64'(done), 0);
      cyc(0, 2'b01, 2'b00, 0);
      cyc(0, 2'b01, 2'b01, 16'd9);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("t3_k4_done", 64'(done), 0);
      cyc(0, 0, 0, 0);
      chk("t3_k5_done", 64'(done), 1);
      chk("t3_k5_status", 64'(status), 2);
      chk("t3_k5_err", 64'(err_latched), 7);
      chk("t3_cycles", 64'(cycle_count), 9);
      chk("t3_commits", commit_count, 6);

      // error beats halt; reset mid-drain
      cyc(1, 0, 0, 0);
      cyc(0, 2'b01, 2'b01, 16'd3);
      chk("t4_status", 64'(status), 2);
      chk("t4_err", 64'(err_latched), 3);
      cyc(0, 0, 0, 0);
      cyc(1, 2'b01, 2'b01, 16'd5);
      chk("t4_rst_done", 64'(done), 0);
      chk("t4_rst_status", 64'(status), 0);
      chk("t4_rst_err", 64'(err_latched), 0);
      chk("t4_rst_cycles", 64'(cycle_count), 0);
      repeat (10) cyc(0, 2'b01, 2'b00, 0);
      chk("t4_never_done", 64'(done), 0);
      chk("t4_cycles", 64'(cycle_count), 10);

      // timeout
      cyc(1, 0, 0, 0);
      repeat (49) cyc(0, 2'b01, 2'b00, 0);
      chk("t5_pre_done", 64'(done), 0);
      cyc(0, 2'b01, 2'b00, 0);
      chk("t5_done", 64'(done), 1);
      chk("t5_status", 64'(status), 3);
      chk("t5_cycles", 64'(cycle_count), 50);
      chk("t5_commits", commit_count, 50);

      // stall
      cyc(1, 0, 0, 0);
      repeat (7) cyc(0, 0, 0, 0);
      chk("t6_pre_done", 64'(done), 0);
      cyc(0, 0, 0, 0);
      chk("t6_done", 64'(done), 1);
      chk("t6_status", 64'(status), 4);
      chk("t6_cycles", 64'(cycle_count), 8);

      // a commit restarts the idle window
      cyc(1, 0, 0, 0);
      repeat (5) cyc(0, 0, 0, 0);
      cyc(0, 2'b10, 2'b00, 0);
      repeat (7) cyc(0, 0, 0, 0);
      chk("t7_pre_done", 64'(done), 0);
      cyc(0, 0, 0, 0);
      chk("t7_done", 64'(done), 1);
      chk("t7_status", 64'(status), 4);
      chk("t7_cycles", 64'(cycle_count), 14);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
